// File: rtl/seq_chk_pkg.sv
// Shared types and helpers for the repetition-sequence checker.
package seq_chk_pkg;

    // Attempt state: waiting for a trigger, or evaluating an attempt.
    typedef enum logic {
        IDLE  = 1'b0,
        MATCH = 1'b1
    } state_t;

    // Outcome of one MATCH-cycle evaluation.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } verdict_t;

    // Width of the repetition counter: must hold 0..max_rep, never less than 1 bit.
    function automatic int calc_cnt_w(input int max_rep);
        int w;
        w = $clog2(max_rep + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seq_repeat_checker_sat_counter.sv
// Saturating event counter: counts inc cycles, holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] r_value;

    // Increment on request until the counter reaches its maximum, then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (inc && (r_value != {WIDTH{1'b1}})) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/seq_repeat_checker.sv
// Monitor for trig ##1 (a[*MIN_REP:MAX_REP] ##1 b), one attempt at a time,
// first-match semantics, registered one-cycle pass/fail verdicts.
module seq_repeat_checker
    import seq_chk_pkg::*;
#(
    parameter int  MIN_REP = 0,
    parameter int  MAX_REP = 3,
    parameter int  DROP_W  = 8,
    localparam int CNT_W   = calc_cnt_w(MAX_REP)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic              a,
    input  logic              b,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [CNT_W-1:0]  reps,
    output logic [DROP_W-1:0] drops,
    output logic              dbg_state
);

    state_t           r_state;
    logic [CNT_W-1:0] r_j;
    logic             r_pass;
    logic             r_fail;
    logic [CNT_W-1:0] r_reps;

    logic             w_min_ok;
    logic             w_room;
    logic             w_drop;
    verdict_t         w_verdict;

    // With MIN_REP == 0 the empty repetition is always acceptable, so the
    // comparison is elaborated away instead of comparing against zero.
    if (MIN_REP == 0) begin : g_min_zero
        assign w_min_ok = 1'b1;
    end else begin : g_min_cmp
        assign w_min_ok = (r_j >= CNT_W'(MIN_REP));
    end

    // With MAX_REP == 0 no 'a' may ever be consumed.
    if (MAX_REP == 0) begin : g_max_zero
        assign w_room = 1'b0;
    end else begin : g_max_cmp
        assign w_room = (r_j < CNT_W'(MAX_REP));
    end

    // Evaluation order gives first-match: b at or past the minimum wins over a.
    always_comb begin
        w_verdict = NONE;
        if (r_state == MATCH) begin
            if (w_min_ok && b) begin
                w_verdict = PASS;
            end else if (w_room && a) begin
                w_verdict = NONE;
            end else begin
                w_verdict = FAIL;
            end
        end
    end

    // Attempt FSM with registered verdict pulses and repetition count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_j     <= '0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_reps  <= '0;
        end else begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (trig) begin
                        r_state <= MATCH;
                        r_j     <= '0;
                    end
                end
                MATCH: begin
                    case (w_verdict)
                        PASS: begin
                            r_pass  <= 1'b1;
                            r_reps  <= r_j;
                            r_state <= IDLE;
                        end
                        FAIL: begin
                            r_fail  <= 1'b1;
                            r_reps  <= r_j;
                            r_state <= IDLE;
                        end
                        default: begin
                            r_j <= r_j + 1'b1;
                        end
                    endcase
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // A trigger seen while an attempt is running (deciding cycle included) is dropped.
    assign w_drop = trig && (r_state == MATCH);

    sat_counter #(
        .WIDTH (DROP_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_drop),
        .value (drops)
    );

    assign busy      = (r_state == MATCH);
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign reps      = r_reps;
    assign dbg_state = (r_state == MATCH);

    a_verdict_excl: assert property (@(posedge clk) disable iff (!rst_n) !(pass && fail));

    // The range check is only meaningful when reps can encode values above MAX_REP.
    if (MAX_REP < ((1 << CNT_W) - 1)) begin : g_reps_range
        a_reps_range: assert property (@(posedge clk) disable iff (!rst_n)
            reps <= CNT_W'(MAX_REP));
    end

    c_empty_pass: cover property (@(posedge clk) disable iff (!rst_n) pass && (reps == '0));
    c_overrun:    cover property (@(posedge clk) disable iff (!rst_n) fail && (reps == CNT_W'(MAX_REP)));
    c_dropped:    cover property (@(posedge clk) disable iff (!rst_n) w_drop);

endmodule

// File: tb/tb_seq_repeat_checker.sv
// Directed bench for seq_repeat_checker: table of vectors for the default
// configuration plus hand-written sequences for reset, minimum, saturation
// and the MAX_REP=0 corner.
module tb_seq_repeat_checker;

    logic clk;
    logic rst_n;
    logic trig;
    logic a;
    logic b;

    // dut0: MIN=0 MAX=3 DROP_W=8
    logic       busy0, pass0, fail0, dbg0;
    logic [1:0] reps0;
    logic [7:0] drops0;
    // dut2: MIN=2 MAX=3 DROP_W=2
    logic       busy2, pass2, fail2, dbg2;
    logic [1:0] reps2;
    logic [1:0] drops2;
    // dutz: MIN=0 MAX=0 DROP_W=8
    logic       busyz, passz, failz, dbgz;
    logic [0:0] repsz;
    logic [7:0] dropsz;

    int checks;
    int errors;

    seq_repeat_checker #(.MIN_REP(0), .MAX_REP(3), .DROP_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .trig(trig), .a(a), .b(b),
        .busy(busy0), .pass(pass0), .fail(fail0), .reps(reps0),
        .drops(drops0), .dbg_state(dbg0)
    );

    seq_repeat_checker #(.MIN_REP(2), .MAX_REP(3), .DROP_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .trig(trig), .a(a), .b(b),
        .busy(busy2), .pass(pass2), .fail(fail2), .reps(reps2),
        .drops(drops2), .dbg_state(dbg2)
    );

    seq_repeat_checker #(.MIN_REP(0), .MAX_REP(0), .DROP_W(8)) dutz (
        .clk(clk), .rst_n(rst_n), .trig(trig), .a(a), .b(b),
        .busy(busyz), .pass(passz), .fail(failz), .reps(repsz),
        .drops(dropsz), .dbg_state(dbgz)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       trig;
        logic       a;
        logic       b;
        logic       busy;
        logic       pass;
        logic       fail;
        logic [1:0] reps;
        logic [7:0] drops;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic r, input logic t, input logic ia, input logic ib,
                                    input logic eb, input logic ep, input logic ef,
                                    input logic [1:0] er, input logic [7:0] ed);
        vec_t v;
        v.rst_n = r; v.trig = t; v.a = ia; v.b = ib;
        v.busy = eb; v.pass = ep; v.fail = ef; v.reps = er; v.drops = ed;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic t, input logic ia, input logic ib);
        rst_n = r; trig = t; a = ia; b = ib;
    endtask

    // advance one clock; sample point is 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        //        rst trig a  b    busy pass fail reps drops
        add_vec(0, 0, 0, 0,   0, 0, 0, 2'd0, 8'd0);  // 0 reset
        add_vec(1, 0, 0, 0,   0, 0, 0, 2'd0, 8'd0);  // 1 idle
        add_vec(1, 0, 1, 1,   0, 0, 0, 2'd0, 8'd0);  // 2 a/b without trig ignored
        add_vec(1, 1, 0, 0,   1, 0, 0, 2'd0, 8'd0);  // 3 empty match: trig
        add_vec(1, 0, 0, 1,   0, 1, 0, 2'd0, 8'd0);  // 4 b at t+1 -> pass reps 0
        add_vec(1, 0, 0, 0,   0, 0, 0, 2'd0, 8'd0);  // 5
        add_vec(1, 1, 0, 0,   1, 0, 0, 2'd0, 8'd0);  // 6 two reps: trig
        add_vec(1, 0, 1, 0,   1, 0, 0, 2'd0, 8'd0);  // 7
        add_vec(1, 0, 1, 0,   1, 0, 0, 2'd0, 8'd0);  // 8
        add_vec(1, 0, 0, 1,   0, 1, 0, 2'd2, 8'd0);  // 9 pass reps 2
        add_vec(1, 0, 0, 0,   0, 0, 0, 2'd0, 8'd0);  // 10
        add_vec(1, 1, 0, 0,   1, 0, 0, 2'd0, 8'd0);  // 11 overrun: trig
        add_vec(1, 0, 1, 0,   1, 0, 0, 2'd0, 8'd0);  // 12
        add_vec(1, 0, 1, 0,   1, 0, 0, 2'd0, 8'd0);  // 13
        add_vec(1, 0, 1, 0,   1, 0, 0, 2'd0, 8'd0);  // 14
        add_vec(1, 0, 1, 0,   0, 0, 1, 2'd3, 8'd0);  // 15 fail reps 3
        add_vec(1, 0, 0, 0,   0, 0, 0, 2'd0, 8'd0);  // 16
        add_vec(1, 1, 0, 0,   1, 0, 0, 2'd0, 8'd0);  // 17 first match: trig
        add_vec(1, 0, 1, 1,   0, 1, 0, 2'd0, 8'd0);  // 18 a and b -> pass reps 0
        add_vec(1, 1, 0, 0,   1, 0, 0, 2'd0, 8'd0);  // 19 trig in verdict-visible cycle accepted
        add_vec(1, 0, 0, 0,   0, 0, 1, 2'd0, 8'd0);  // 20 neither a nor b -> fail reps 0
        add_vec(1, 1, 1, 0,   1, 0, 0, 2'd0, 8'd0);  // 21 held trig
        add_vec(1, 1, 1, 0,   1, 0, 0, 2'd0, 8'd1);  // 22
        add_vec(1, 1, 1, 0,   1, 0, 0, 2'd0, 8'd2);  // 23
        add_vec(1, 1, 1, 0,   1, 0, 0, 2'd0, 8'd3);  // 24
        add_vec(1, 1, 1, 0,   0, 0, 1, 2'd3, 8'd4);  // 25 fail, deciding-cycle trig dropped
        add_vec(1, 1, 1, 0,   1, 0, 0, 2'd0, 8'd4);  // 26 new attempt accepted
        add_vec(1, 0, 0, 1,   0, 1, 0, 2'd0, 8'd4);  // 27 pass reps 0
        add_vec(0, 0, 0, 0,   0, 0, 0, 2'd0, 8'd0);  // 28 reset clears drops

        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].trig, vecs[i].a, vecs[i].b);
            step();
            chk($sformatf("v%0d busy", i), busy0, vecs[i].busy);
            chk($sformatf("v%0d dbg_state", i), dbg0, vecs[i].busy);
            chk($sformatf("v%0d pass", i), pass0, vecs[i].pass);
            chk($sformatf("v%0d fail", i), fail0, vecs[i].fail);
            chk($sformatf("v%0d drops", i), drops0, vecs[i].drops);
            if (vecs[i].pass || vecs[i].fail)
                chk($sformatf("v%0d reps", i), reps0, vecs[i].reps);
        end

        // reset mid-attempt on dut0
        drive(1, 0, 0, 0); step();
        drive(1, 1, 0, 0); step();
        chk("rst_mid busy before", busy0, 1);
        drive(1, 0, 1, 0); step();
        chk("rst_mid busy rep1", busy0, 1);
        drive(0, 0, 1, 0);
        #1;
        chk("rst_mid async busy", busy0, 0);
        chk("rst_mid async pass", pass0, 0);
        chk("rst_mid async fail", fail0, 0);
        chk("rst_mid async reps", reps0, 0);
        chk("rst_mid async drops", drops0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 1); step();
            chk($sformatf("rst_mid held%0d verdict", k), {pass0, fail0, busy0}, 3'b000);
        end
        drive(1, 0, 0, 1); step();
        chk("rst_mid release verdict", {pass0, fail0, busy0}, 3'b000);
        drive(1, 0, 0, 0); step();
        chk("rst_mid release2 verdict", {pass0, fail0, busy0}, 3'b000);

        // minimum enforced on dut2 (MIN=2): early b ignored
        drive(1, 1, 0, 0); step();
        chk("min busy", busy2, 1);
        drive(1, 0, 1, 1); step();
        chk("min j1 pass", {pass2, fail2, busy2}, 3'b001);
        step();
        chk("min j2 pass", {pass2, fail2, busy2}, 3'b001);
        step();
        chk("min verdict", {pass2, fail2, busy2}, 3'b100);
        chk("min reps", reps2, 2);
        drive(1, 0, 0, 0); step();
        chk("min after", {pass2, fail2, busy2}, 3'b000);

        // b below minimum with no a -> fail at j=0
        drive(1, 1, 0, 0); step();
        drive(1, 0, 0, 1); step();
        chk("min early b verdict", {pass2, fail2, busy2}, 3'b010);
        chk("min early b reps", reps2, 0);
        drive(1, 0, 0, 0); step();

        // drop counter saturation on dut2 (DROP_W=2)
        chk("sat start", drops2, 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 1, 0); step();
        end
        chk("sat verdict", {pass2, fail2, busy2}, 3'b010);
        chk("sat reps", reps2, 3);
        chk("sat drops", drops2, 3);
        drive(1, 0, 0, 0); step();
        chk("sat hold", drops2, 3);

        // MAX_REP=0 on dutz
        drive(0, 0, 0, 0); step();
        drive(1, 0, 0, 0); step();
        drive(1, 1, 0, 0); step();
        chk("max0 busy", busyz, 1);
        drive(1, 0, 1, 1); step();
        chk("max0 pass", {passz, failz, busyz}, 3'b100);
        chk("max0 pass reps", repsz, 0);
        drive(1, 1, 0, 0); step();
        drive(1, 0, 1, 0); step();
        chk("max0 a-only fail", {passz, failz, busyz}, 3'b010);
        chk("max0 fail reps", repsz, 0);
        drive(1, 0, 0, 0); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
